// File: rtl/vc_sram_memreq_adapter.sv
// vc_sram_memreq_adapter: val/rdy front-end for a single-port synchronous SRAM.
// Requests drive the SRAM port on the accept cycle. The one-cycle-late read data
// is either bypassed straight to the response port or parked in a small
// in-order response queue, so the requester can stall responses without loss.
// Optional build macro VC_SRAM_MEMREQ_ADAPTER_RESP_REG_EN: removes the bypass
// path, so responses come only from the queue (registered outputs). The queue
// grows to 3 entries and latency becomes 2 cycles.
module vc_sram_memreq_adapter #(
    parameter  int p_data_nbits  = 32,
    parameter  int p_num_entries = 256,
    localparam int c_addr_nbits  = $clog2(p_num_entries),
    localparam int c_data_nbytes = (p_data_nbits + 7) / 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     memreq_val,
    output logic                     memreq_rdy,
    input  logic                     memreq_type,
    input  logic [c_addr_nbits-1:0]  memreq_addr,
    input  logic [c_data_nbytes-1:0] memreq_byte_en,
    input  logic [p_data_nbits-1:0]  memreq_data,
    output logic                     memresp_val,
    input  logic                     memresp_rdy,
    output logic                     memresp_type,
    output logic [p_data_nbits-1:0]  memresp_data,
    output logic                     sram_read_en,
    output logic                     sram_write_en,
    output logic [c_addr_nbits-1:0]  sram_read_addr,
    output logic [c_addr_nbits-1:0]  sram_write_addr,
    output logic [c_data_nbytes-1:0] sram_write_byte_en,
    output logic [p_data_nbits-1:0]  sram_write_data,
    input  logic [p_data_nbits-1:0]  sram_read_data
);

`ifdef VC_SRAM_MEMREQ_ADAPTER_RESP_REG_EN
    localparam int DEPTH = 3;
`else
    localparam int DEPTH = 2;
`endif
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                                f_val_q, f_type_q;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [PTR_W-1:0]                    wr_ptr_q, rd_ptr_q;
    logic [DEPTH-1:0]                    typ_q;
    logic [DEPTH-1:0][p_data_nbits-1:0]  dat_q;
    logic                                fire, resp_fire, enq, deq, bypass;
    logic [p_data_nbits-1:0]             f_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready looks only at registered occupancy (queue + in-flight), never at
    // memresp_rdy, so an accepted request always has a queue slot waiting.
    assign memreq_rdy = reset &&
        (((CNT_W+1)'(cnt_q) + (CNT_W+1)'(f_val_q)) < (CNT_W+1)'(DEPTH));
    assign fire       = memreq_val && memreq_rdy;

    assign sram_read_en       = fire && !memreq_type;
    assign sram_write_en      = fire &&  memreq_type;
    assign sram_read_addr     = memreq_addr;
    assign sram_write_addr    = memreq_addr;
    assign sram_write_byte_en = memreq_byte_en;
    assign sram_write_data    = memreq_data;

    // Writes respond with all-zero data; idle cycles also present zero.
    assign f_data = (f_val_q && !f_type_q) ? sram_read_data : '0;

    // Response mux: queue head has priority to keep strict request order.
    always_comb begin
        memresp_val  = 1'b0;
        memresp_type = 1'b0;
        memresp_data = '0;
        bypass       = 1'b0;
        if (cnt_q != '0) begin
            memresp_val  = 1'b1;
            memresp_type = typ_q[rd_ptr_q];
            memresp_data = dat_q[rd_ptr_q];
        end
`ifndef VC_SRAM_MEMREQ_ADAPTER_RESP_REG_EN
        else begin
            memresp_val  = f_val_q;
            memresp_type = f_type_q;
            memresp_data = f_data;
            bypass       = f_val_q && memresp_rdy;
        end
`endif
    end

    assign resp_fire = memresp_val && memresp_rdy;
    assign deq       = (cnt_q != '0) && resp_fire;
    assign enq       = f_val_q && !bypass;

    // Occupancy next-state; enq and deq together leave it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (enq && !deq)      cnt_d = cnt_q + 1'b1;
        else if (!enq && deq) cnt_d = cnt_q - 1'b1;
    end

    // In-flight tracking and response queue storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_val_q  <= 1'b0;
            f_type_q <= 1'b0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            typ_q    <= '0;
            dat_q    <= '0;
        end else begin
            f_val_q  <= fire;
            f_type_q <= memreq_type;
            cnt_q    <= cnt_d;
            if (enq) begin
                typ_q[wr_ptr_q] <= f_type_q;
                dat_q[wr_ptr_q] <= f_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (deq) rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

endmodule

// File: tb/tb_vc_sram_memreq_adapter.sv
// Bench for vc_sram_memreq_adapter: behavioural SRAM plus a transaction-level
// reference (memory image + ordered queue of expected responses with their
// accept cycle). Directed test-plan sequences followed by random traffic.
module tb_vc_sram_memreq_adapter;

`ifdef VC_SRAM_MEMREQ_ADAPTER_RESP_REG_EN
    localparam int DEPTH = 3;
    localparam int LAT   = 2;
`else
    localparam int DEPTH = 2;
    localparam int LAT   = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memreq_val = 1'b0, memreq_rdy, memreq_type = 1'b0;
    logic [7:0]  memreq_addr = '0;
    logic [3:0]  memreq_byte_en = '0;
    logic [31:0] memreq_data = '0;
    logic        memresp_val, memresp_rdy = 1'b0, memresp_type;
    logic [31:0] memresp_data;
    logic        sram_read_en, sram_write_en;
    logic [7:0]  sram_read_addr, sram_write_addr;
    logic [3:0]  sram_write_byte_en;
    logic [31:0] sram_write_data;
    logic [31:0] sram_read_data = '0;

    vc_sram_memreq_adapter dut (
        .clk(clk), .reset(reset),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_type(memreq_type),
        .memreq_addr(memreq_addr), .memreq_byte_en(memreq_byte_en), .memreq_data(memreq_data),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_type(memresp_type),
        .memresp_data(memresp_data),
        .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
        .sram_read_addr(sram_read_addr), .sram_write_addr(sram_write_addr),
        .sram_write_byte_en(sram_write_byte_en), .sram_write_data(sram_write_data),
        .sram_read_data(sram_read_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] seed(input int i);
        return 32'(i * 32'h0001_0203) ^ 32'h5A00_0000;
    endfunction

    // Behavioural single-port SRAM; preloaded while mem_init is high.
    logic [31:0] sram_mem [256];
    logic        mem_init = 1'b1;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= seed(i);
        end else begin
            if (sram_read_en) sram_read_data <= sram_mem[sram_read_addr];
            if (sram_write_en)
                for (int b = 0; b < 4; b++)
                    if (sram_write_byte_en[b])
                        sram_mem[sram_write_addr][8*b +: 8] <= sram_write_data[8*b +: 8];
        end
    end

    // Reference state
    logic [31:0] ref_mem [256];
    logic        exp_typ [$];
    logic [31:0] exp_dat [$];
    int          exp_cyc [$];
    int          cyc = 0;
    int          n_fire = 0, n_rd = 0, n_resp = 0;
    logic [31:0] last_rd_data = '0;
    int          errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive at negedge, check and update model at negedge+1.
    task automatic step(input logic v, input logic t, input logic [7:0] a,
                        input logic [3:0] be, input logic [31:0] d, input logic rr);
        logic rdy_exp, vis, fire;
        @(negedge clk);
        memreq_val = v; memreq_type = t; memreq_addr = a;
        memreq_byte_en = be; memreq_data = d; memresp_rdy = rr;
        #1;
        rdy_exp = reset && (exp_typ.size() < DEPTH);
        chk("req_rdy", 32'(memreq_rdy), 32'(rdy_exp));
        vis = (exp_typ.size() > 0) && (cyc >= exp_cyc[0] + LAT);
        chk("resp_val", 32'(memresp_val), 32'(vis));
        if (vis) begin
            chk("resp_type", 32'(memresp_type), 32'(exp_typ[0]));
            chk("resp_data", memresp_data, exp_dat[0]);
            if (rr) begin
                if (!exp_typ[0]) last_rd_data = memresp_data;
                void'(exp_typ.pop_front()); void'(exp_dat.pop_front()); void'(exp_cyc.pop_front());
                n_resp++;
            end
        end
        fire = v && rdy_exp;
        chk("rd_en", 32'(sram_read_en), 32'(fire && !t));
        chk("wr_en", 32'(sram_write_en), 32'(fire && t));
        if (fire) begin
            n_fire++;
            exp_typ.push_back(t);
            exp_cyc.push_back(cyc);
            if (t) begin
                chk("wr_addr", 32'(sram_write_addr), 32'(a));
                chk("wr_data", sram_write_data, d);
                chk("wr_be", 32'(sram_write_byte_en), 32'(be));
                exp_dat.push_back(32'h0);
                for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
            end else begin
                n_rd++;
                chk("rd_addr", 32'(sram_read_addr), 32'(a));
                exp_dat.push_back(ref_mem[a]);
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h0, 4'h0, 32'h0, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_rdy"}, 32'(memreq_rdy), 32'h0);
        chk({tag, "_resp_val"}, 32'(memresp_val), 32'h0);
        chk({tag, "_rd_en"}, 32'(sram_read_en), 32'h0);
        chk({tag, "_wr_en"}, 32'(sram_write_en), 32'h0);
        chk({tag, "_resp_type"}, 32'(memresp_type), 32'h0);
        chk({tag, "_resp_data"}, memresp_data, 32'h0);
    endtask

    initial begin
        int n0, r0, d0;
        for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);

        // Reset state, with a request presented the whole time.
        memreq_val = 1'b1; memreq_type = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("rst");
        mem_init = 1'b0;
        reset = 1'b1;
        memreq_val = 1'b0;

        // Write then read address 5; byte-enabled overwrite then readback.
        step(1'b1, 1'b1, 8'd5, 4'hF, 32'hDEADBEEF, 1'b1);
        step(1'b1, 1'b0, 8'd5, 4'h0, 32'h0, 1'b1);
        idle(3);
        chk("wr_rd_readback", last_rd_data, 32'hDEADBEEF);
        step(1'b1, 1'b1, 8'd5, 4'b0101, 32'h11223344, 1'b1);
        step(1'b1, 1'b0, 8'd5, 4'h0, 32'h0, 1'b1);
        idle(3);
        chk("be_readback", last_rd_data, 32'hDE22BE44);

        // Backpressure: consumer stalled, four reads offered.
        n0 = n_fire; d0 = n_resp;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(i + 8), 4'h0, 32'h0, 1'b0);
        #1;
        chk("bp_fires", 32'(n_fire - n0), 32'(DEPTH));
        chk("bp_rdy_low", 32'(memreq_rdy), 32'h0);
        idle(5);
        chk("bp_drained", 32'(n_resp - d0), 32'(DEPTH));

        // Streaming 16 back-to-back reads.
        r0 = n_rd; d0 = n_resp;
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i), 4'h0, 32'h0, 1'b1);
        idle(4);
        chk("stream_reads", 32'(n_rd - r0), 32'd16);
        chk("stream_resps", 32'(n_resp - d0), 32'd16);

        // Reset mid-operation with responses pending.
        step(1'b1, 1'b0, 8'd1, 4'h0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 8'd2, 4'h0, 32'h0, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_reset_outputs("midrst");
        exp_typ.delete(); exp_dat.delete(); exp_cyc.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        memreq_val = 1'b0;
        idle(3);

        // Random traffic over a small address window.
        for (int i = 0; i < 600; i++) begin
            step(1'b1 && ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 7)), 4'($urandom), $urandom,
                 ($urandom_range(0, 9) < 7));
        end
        idle(6);
        chk("final_empty", 32'(exp_typ.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
